// File: rtl/x_scope_dump_if.sv
// Signal bundle between the scope-dump sequencer and its neighbours: run control,
// micro-scope capture/read port and UART TX byte port.
interface x_scope_dump_if #(
    parameter int AW = 11
);
    logic          i_go;
    logic          i_abort;
    logic          o_busy;
    logic          o_done;
    logic          o_scope_start;
    logic          i_scope_busy;
    logic          o_scope_ren;
    logic [AW-1:0] o_scope_raddr;
    logic [31:0]   i_scope_rdata;
    logic [7:0]    o_tx_data;
    logic          o_tx_valid;
    logic          i_tx_accept;

    // master: the environment (host control, scope, UART); slave: the sequencer
    modport master (
        output i_go, i_abort, i_scope_busy, i_scope_rdata, i_tx_accept,
        input  o_busy, o_done, o_scope_start, o_scope_ren, o_scope_raddr,
               o_tx_data, o_tx_valid
    );

    modport slave (
        input  i_go, i_abort, i_scope_busy, i_scope_rdata, i_tx_accept,
        output o_busy, o_done, o_scope_start, o_scope_ren, o_scope_raddr,
               o_tx_data, o_tx_valid
    );
endinterface

// File: rtl/x_scope_dump.sv
// Micro-scope readback sequencer: triggers a capture, then streams words 0..DEPTH-1 to the UART TX, LSB first.
// Define X_SCOPE_DUMP_HDR_EN to prefix each dump with the header bytes 0xA5, DEPTH[7:0], DEPTH[15:8].
//
// state   | meaning
// IDLE    | waiting for go
// START   | scope start pulse
// WAIT_HI | waiting for scope busy to rise; timeout treats capture as done
// WAIT_LO | waiting for scope capture to finish
// HDR     | header bytes (header build only)
// READ    | read-enable pulse for the current address
// LAT     | waiting out read latency, then capture the word
// SEND    | four bytes of the captured word to the UART
module x_scope_dump #(
    parameter int DEPTH   = 2048,
    parameter int AW      = 11,
    parameter int RD_LAT  = 1,
    parameter int BUSY_TO = 15
) (
    input logic           i_clk,
    input logic           i_rst,
    x_scope_dump_if.slave bus
);
    localparam int TMAX = (BUSY_TO > RD_LAT) ? BUSY_TO : RD_LAT;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
`ifdef X_SCOPE_DUMP_HDR_EN
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_WAIT_LO,
`ifdef X_SCOPE_DUMP_HDR_EN
        S_HDR,
`endif
        S_READ,
        S_LAT,
        S_SEND
    } state_t;

    state_t        state;
    logic [AW-1:0] addr;
    logic [1:0]    idx;
    logic [TW-1:0] tmr;
    logic [31:0]   word_buf;
    logic          abort_pend;
    logic          done_r;
    logic          start_r;
    logic          ren_r;
    logic          valid_r;
    logic [7:0]    data_r;
    logic [1:0]    idx_nxt;
    logic          take;
    logic          capture_done;

    assign idx_nxt      = idx + 2'd1;
    assign take         = valid_r & bus.i_tx_accept;
    assign capture_done = !bus.i_scope_busy && ((state == S_WAIT_LO) || (tmr == '0));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            addr       <= '0;
            idx        <= 2'd0;
            tmr        <= '0;
            word_buf   <= 32'd0;
            abort_pend <= 1'b0;
            done_r     <= 1'b0;
            start_r    <= 1'b0;
            ren_r      <= 1'b0;
            valid_r    <= 1'b0;
            data_r     <= 8'd0;
        end else begin
            done_r  <= 1'b0;
            start_r <= 1'b0;
            ren_r   <= 1'b0;
            case (state)
                S_IDLE: begin
                    // abort is not looked at here, so go wins over a simultaneous abort
                    if (bus.i_go) begin
                        state      <= S_START;
                        start_r    <= 1'b1;
                        addr       <= '0;
                        idx        <= 2'd0;
                        abort_pend <= 1'b0;
                    end
                end
                S_START: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_WAIT_HI;
                        tmr   <= TW'(BUSY_TO - 1);
                    end
                end
                S_WAIT_HI, S_WAIT_LO: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                    end else if (capture_done) begin
`ifdef X_SCOPE_DUMP_HDR_EN
                        state   <= S_HDR;
                        data_r  <= 8'hA5;
                        valid_r <= 1'b1;
                        idx     <= 2'd0;
`else
                        state <= S_READ;
                        ren_r <= 1'b1;
`endif
                    end else if (state == S_WAIT_HI) begin
                        if (bus.i_scope_busy) state <= S_WAIT_LO;
                        else                  tmr   <= tmr - 1'b1;
                    end
                end
`ifdef X_SCOPE_DUMP_HDR_EN
                S_HDR: begin
                    if (take) begin
                        if (abort_pend || bus.i_abort) begin
                            state   <= S_IDLE;
                            valid_r <= 1'b0;
                        end else if (idx == 2'd2) begin
                            state   <= S_READ;
                            valid_r <= 1'b0;
                            ren_r   <= 1'b1;
                            idx     <= 2'd0;
                        end else begin
                            idx    <= idx_nxt;
                            data_r <= (idx == 2'd0) ? DEPTH_W[7:0] : DEPTH_W[15:8];
                        end
                    end else if (bus.i_abort) begin
                        abort_pend <= 1'b1;
                    end
                end
`endif
                S_READ: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_LAT;
                        tmr   <= TW'(RD_LAT - 1);
                    end
                end
                S_LAT: begin
                    if (bus.i_abort) begin
                        state <= S_IDLE;
                    end else if (tmr == '0) begin
                        state    <= S_SEND;
                        word_buf <= bus.i_scope_rdata;
                        data_r   <= bus.i_scope_rdata[7:0];
                        valid_r  <= 1'b1;
                        idx      <= 2'd0;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                S_SEND: begin
                    // an abort seen while a byte is pending takes effect once that byte is accepted
                    if (take) begin
                        if (abort_pend || bus.i_abort) begin
                            state   <= S_IDLE;
                            valid_r <= 1'b0;
                        end else if (idx == 2'd3) begin
                            valid_r <= 1'b0;
                            if (addr == LAST_ADDR) begin
                                state  <= S_IDLE;
                                done_r <= 1'b1;
                            end else begin
                                state <= S_READ;
                                addr  <= addr + 1'b1;
                                ren_r <= 1'b1;
                            end
                        end else begin
                            idx    <= idx_nxt;
                            data_r <= word_buf[{idx_nxt, 3'b000} +: 8];
                        end
                    end else if (bus.i_abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_busy        = (state != S_IDLE);
    assign bus.o_done        = done_r;
    assign bus.o_scope_start = start_r;
    assign bus.o_scope_ren   = ren_r;
    assign bus.o_scope_raddr = addr;
    assign bus.o_tx_data     = data_r;
    assign bus.o_tx_valid    = valid_r;
endmodule
